exe_mul_sequencer: RTL

Multi-cycle shift-add multiplier sequencer for MUL/MLA instructions, sitting beside the EXE-stage ALU. It accepts an issue strobe from the ID/EX register and holds the pipeline with `busy` while it iterates. It then delivers the 32-bit product on a one-cycle `done` pulse, together with N/Z status-register updates, for capture into EX/MEM.

---
 rtl/exe_pkg.sv | 20 ++
 rtl/mul_shift_add_dp.sv | 63 ++++++
 rtl/exe_mul_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the EXE-stage multiplier: FSM states, command
// encodings, status-register bit positions and the default datapath width.
`timescale 1ns/1ps
package exe_pkg;
    localparam int EXE_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam logic [3:0] EXE_CMD_MUL = 4'hA;
    localparam logic [3:0] EXE_CMD_MLA = 4'hB;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;
endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: operand/product registers, the adder and the
// iteration counter. The sequencer drives load/step and watches last_step.
`timescale 1ns/1ps
module mul_shift_add_dp
    import exe_pkg::*;
#(
    parameter int WIDTH = EXE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             acc,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_acc,
    output logic [WIDTH-1:0] prod_step,
    output logic             last_step
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // prod_step is the product after the current iteration, used both as the
    // next register value and as the final result on the last step.
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            prod_d   = acc ? op_acc : '0;
            cnt_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            prod_d   = prod_step;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/exe_mul_sequencer.sv
// MUL/MLA sequencer beside the EXE ALU: freezes the pipeline while the
// shift-add datapath iterates, then pulses done with result and N/Z flags.
`timescale 1ns/1ps
module exe_mul_sequencer
    import exe_pkg::*;
#(
    parameter int WIDTH = EXE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc,
    input  logic             S,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_acc,
    input  logic [3:0]       sr_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status_out,
    output logic             status_we
);
    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       status_q, status_d;
    logic             done_q, done_d;
    logic             we_q, we_d;
    logic             s_q, s_d;

    logic             load;
    logic             step;
    logic [WIDTH-1:0] prod_step;
    logic             last_step;
    logic             unused_sr;

    assign unused_sr = ^sr_in[3:2];

    assign load = (state_q == IDLE) && start && !flush;
    assign step = (state_q == RUN) && !flush;
    // Combinational so the issuing instruction is held in its own cycle.
    assign busy = (state_q == RUN) || load;

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .acc       (acc),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_acc    (op_acc),
        .prod_step (prod_step),
        .last_step (last_step)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        status_d = status_q;
        done_d   = 1'b0;
        we_d     = 1'b0;
        s_d      = s_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = RUN;
                    s_d     = S;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d          = DONE;
                    result_d         = prod_step;
                    status_d[SR_N]   = prod_step[WIDTH-1];
                    status_d[SR_Z]   = (prod_step == '0);
                    status_d[SR_C]   = sr_in[SR_C];
                    status_d[SR_V]   = sr_in[SR_V];
                    done_d           = 1'b1;
                    we_d             = s_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            s_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            status_q <= status_d;
            done_q   <= done_d;
            we_q     <= we_d;
            s_q      <= s_d;
        end
    end

    assign done       = done_q;
    assign status_we  = we_q;
    assign result     = result_q;
    assign status_out = status_q;
endmodule
